// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-channel button synchroniser, debounce filter and edge pulses
//
// Purpose:
//   Conditions N_BTN raw asynchronous button inputs. Each channel is
//   synchronised through two flops. The synchronised level must then disagree
//   with the accepted level for DEBOUNCE_CYCLES consecutive cycles before it is
//   taken as the new debounced level. On the edge that changes a level, a
//   one-cycle press or release pulse is registered. A lowest-index-wins
//   summary of the press vector is also registered.
//
// Ports:
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous active-low reset
//   btn_raw      in   N_BTN  raw asynchronous button inputs, active-high
//   btn_level    out  N_BTN  debounced level, registered
//   btn_press    out  N_BTN  one-cycle pulse on debounced 0->1
//   btn_release  out  N_BTN  one-cycle pulse on debounced 1->0
//   press_valid  out  1      OR of btn_press, aligned with it
//   press_idx    out  3      lowest set index of btn_press, 0 when none

module btn_debounce #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             press_valid,
  output logic [2:0]       press_idx
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic             valid_q, valid_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  // Filter: any cycle where s2 agrees with the accepted level restarts the
  // count, so only an uninterrupted run of disagreement is accepted.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Pulses derived from next-state level so they land on the changing edge.
  always_comb begin
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    valid_d   = |press_d;
    idx_d     = 3'd0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press_d[i]) idx_d = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= 3'd0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign press_valid = valid_q;
  assign press_idx   = idx_q;

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed self-checking bench for btn_debounce

module tb_btn_debounce;

  logic       clk;
  logic       rst_n;
  logic [7:0] btn_raw;
  logic [7:0] btn_level;
  logic [7:0] btn_press;
  logic [7:0] btn_release;
  logic       press_valid;
  logic [2:0] press_idx;

  int tests = 0;
  int fails = 0;

  btn_debounce #(
    .N_BTN          (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .press_valid(press_valid),
    .press_idx  (press_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] lvl, input logic [7:0] prs,
                           input logic [7:0] rel, input logic vld, input logic [2:0] idx);
    check({tag, ".level"},   btn_level,   lvl);
    check({tag, ".press"},   btn_press,   prs);
    check({tag, ".release"}, btn_release, rel);
    check({tag, ".valid"},   {7'd0, press_valid}, {7'd0, vld});
    check({tag, ".idx"},     {5'd0, press_idx},   {5'd0, idx});
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 8'h00;
    repeat (3) step();
    check_all("reset", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    rst_n = 1'b1;

    // T1 clean press on channel 3: level rises on edge 6.
    btn_raw = 8'h08;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_all("t1.wait", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    end
    step();
    check_all("t1.edge6", 8'h08, 8'h08, 8'h00, 1'b1, 3'd3);
    for (int k = 0; k < 4; k++) begin
      step();
      check_all("t1.held", 8'h08, 8'h00, 8'h00, 1'b0, 3'd0);
    end

    // T4 release of channel 3.
    btn_raw = 8'h00;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_all("t4.wait", 8'h08, 8'h00, 8'h00, 1'b0, 3'd0);
    end
    step();
    check_all("t4.edge6", 8'h00, 8'h00, 8'h08, 1'b0, 3'd0);
    step();
    check_all("t4.after", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);

    // T2 glitch: channel 0 high for 3 cycles only.
    btn_raw = 8'h01;
    for (int k = 0; k < 3; k++) begin
      step();
      check_all("t2.high", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    end
    btn_raw = 8'h00;
    for (int k = 0; k < 8; k++) begin
      step();
      check_all("t2.low", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    end

    // T3 bounce 1,0,1,0,1 then held on channel 5.
    btn_raw = 8'h20; step();
    btn_raw = 8'h00; step();
    btn_raw = 8'h20; step();
    btn_raw = 8'h00; step();
    check_all("t3.bounce", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    btn_raw = 8'h20;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_all("t3.wait", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    end
    step();
    check_all("t3.edge6", 8'h20, 8'h20, 8'h00, 1'b1, 3'd5);
    for (int k = 0; k < 3; k++) begin
      step();
      check_all("t3.held", 8'h20, 8'h00, 8'h00, 1'b0, 3'd0);
    end
    btn_raw = 8'h00;
    repeat (8) step();
    check("t3.cleared", btn_level, 8'h00);

    // T5 channels 2 and 5 rise together.
    btn_raw = 8'h24;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_all("t5.wait", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    end
    step();
    check_all("t5.edge6", 8'h24, 8'h24, 8'h00, 1'b1, 3'd2);
    step();
    check_all("t5.after", 8'h24, 8'h00, 8'h00, 1'b0, 3'd0);
    btn_raw = 8'h00;
    repeat (8) step();
    check("t5.cleared", btn_level, 8'h00);

    // T6 reset mid-count on channel 7.
    btn_raw = 8'h80;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check_all("t6.inreset", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      check_all("t6.held", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_all("t6.wait", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    end
    step();
    check_all("t6.edge6", 8'h80, 8'h80, 8'h00, 1'b1, 3'd7);
    for (int k = 0; k < 3; k++) begin
      step();
      check_all("t6.held2", 8'h80, 8'h00, 8'h00, 1'b0, 3'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
